// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: data widths
// and the loader FSM state encoding.
package program_loader_pkg;

    localparam int WORD      = 32;
    localparam int HALF_WORD = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        DONE
    } loader_state_t;

endpackage

// File: rtl/program_loader_halfword_assembler.sv
// Pairs stream bytes into little-endian halfwords and issues one registered
// write strobe per halfword, stepping the instruction address after each write.
module program_loader_halfword_assembler
    import program_loader_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR = '0,
    parameter logic [WORD-1:0] ADDR_STEP = WORD'(2)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 init_i,
    input  logic                 lo_en_i,
    input  logic                 hi_en_i,
    input  logic [7:0]           byte_i,
    output logic                 write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o
);

    logic [7:0]           low_byte_p0;
    logic [HALF_WORD-1:0] instr_p1;
    logic [WORD-1:0]      addr_p1;
    logic                 wr_vld_p1;

    // p0: low byte held until its partner arrives
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            low_byte_p0 <= '0;
        end else if (lo_en_i) begin
            low_byte_p0 <= byte_i;
        end
    end

    // p1: halfword, address and strobe presented together to memory.
    // The address advances on the strobe cycle, so it is stable while the
    // strobe is high and already points at the next slot afterwards.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            instr_p1  <= '0;
            addr_p1   <= BASE_ADDR;
            wr_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= hi_en_i;
            if (hi_en_i) begin
                instr_p1 <= {byte_i, low_byte_p0};
            end
            if (init_i) begin
                addr_p1 <= BASE_ADDR;
            end else if (wr_vld_p1) begin
                addr_p1 <= addr_p1 + ADDR_STEP;
            end
        end
    end

    assign write_en_o         = wr_vld_p1;
    assign instruction_o      = instr_p1;
    assign instruction_addr_o = addr_p1;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: header + little-endian halfwords into instruction
// memory, CPU held in reset meanwhile. PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR = '0,
    parameter logic [WORD-1:0] ADDR_STEP = WORD'(2),
    parameter logic [15:0]     MAX_LEN   = 16'hFFFF
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 byte_ready_o,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 cpu_hold_o,
    output logic                 load_done_o,
    output logic                 load_error_o
);

    function automatic logic [15:0] sat_len(input logic [15:0] raw);
        return (raw > MAX_LEN) ? MAX_LEN : raw;
    endfunction

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [15:0]   count;
    logic [15:0]   hdr_len;
    logic          xfer;
    logic          arm;
    logic          lo_en;
    logic          hi_en;
    logic          last_hw;

    assign xfer    = byte_valid_i && byte_ready_o;
    assign arm     = start_i && ((state == IDLE) || (state == DONE));
    assign lo_en   = xfer && (state == DATA_LO);
    assign hi_en   = xfer && (state == DATA_HI);
    assign hdr_len = sat_len({byte_i, len_lo});
    assign last_hw = (count + 16'd1) == len;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       load_err_q;
    assign load_error_o = load_err_q;
`else
    assign load_error_o = 1'b0;
`endif

    // byte_ready_o is updated on every transition so it always mirrors the
    // state being entered: high only in the byte-consuming states.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            byte_ready_o <= 1'b0;
            cpu_hold_o   <= 1'b0;
            load_done_o  <= 1'b0;
            len_lo       <= '0;
            len          <= '0;
            count        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= '0;
            load_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state        <= LEN_LO;
                        byte_ready_o <= 1'b1;
                        cpu_hold_o   <= 1'b1;
                        load_done_o  <= 1'b0;
                        count        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum         <= '0;
                        load_err_q   <= 1'b0;
`endif
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_lo <= byte_i;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len <= hdr_len;
                        if (hdr_len == 16'd0) begin
                            state        <= DONE;
                            byte_ready_o <= 1'b0;
                            cpu_hold_o   <= 1'b0;
                            load_done_o  <= 1'b1;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        state <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        count <= count + 16'd1;
                        if (last_hw) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state        <= CSUM;
`else
                            state        <= DONE;
                            byte_ready_o <= 1'b0;
                            cpu_hold_o   <= 1'b0;
                            load_done_o  <= 1'b1;
`endif
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (xfer) begin
                        load_err_q   <= (byte_i != csum);
                        state        <= DONE;
                        byte_ready_o <= 1'b0;
                        cpu_hold_o   <= 1'b0;
                        load_done_o  <= 1'b1;
                    end
`else
                    state        <= IDLE;
                    byte_ready_o <= 1'b0;
                    cpu_hold_o   <= 1'b0;
`endif
                end
                default: begin
                    state        <= IDLE;
                    byte_ready_o <= 1'b0;
                    cpu_hold_o   <= 1'b0;
                end
            endcase
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            // Running XOR over header and data; the checksum byte itself is excluded.
            if (xfer && (state != CSUM)) begin
                csum <= csum ^ byte_i;
            end
`endif
        end
    end

    program_loader_halfword_assembler #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_STEP (ADDR_STEP)
    ) u_asm (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .init_i             (arm),
        .lo_en_i            (lo_en),
        .hi_en_i            (hi_en),
        .byte_i             (byte_i),
        .write_en_o         (program_mem_write_en_o),
        .instruction_o      (instruction_o),
        .instruction_addr_o (instruction_addr_o)
    );

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (base 0 and base FFFF_FFFE)
// share one byte stream; expected writes are queued as bytes are driven.
module tb_program_loader;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        rdy0, we0, hold0, done0, err0;
    logic [15:0] instr0;
    logic [31:0] addr0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [15:0] instr1;
    logic [31:0] addr1;

    int total = 0;
    int bad = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];
    logic [15:0] hw_buf[8];

    always #5 clk = ~clk;

    program_loader dut0 (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .start_i                (start),
        .byte_valid_i           (byte_valid),
        .byte_i                 (byte_in),
        .byte_ready_o           (rdy0),
        .program_mem_write_en_o (we0),
        .instruction_o          (instr0),
        .instruction_addr_o     (addr0),
        .cpu_hold_o             (hold0),
        .load_done_o            (done0),
        .load_error_o           (err0)
    );

    program_loader #(.BASE_ADDR(BASE1)) dut1 (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .start_i                (start),
        .byte_valid_i           (byte_valid),
        .byte_i                 (byte_in),
        .byte_ready_o           (rdy1),
        .program_mem_write_en_o (we1),
        .instruction_o          (instr1),
        .instruction_addr_o     (addr1),
        .cpu_hold_o             (hold1),
        .load_done_o            (done1),
        .load_error_o           (err1)
    );

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        logic [47:0] e;
        if (we0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL write0_unexpected got addr=%h instr=%h want no write", addr0, instr0);
            end else begin
                e = q0.pop_front();
                if ({addr0, instr0} !== e) begin
                    bad++;
                    $display("FAIL write0 got addr=%h instr=%h want addr=%h instr=%h",
                             addr0, instr0, e[47:16], e[15:0]);
                end
            end
        end
        if (we1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL write1_unexpected got addr=%h instr=%h want no write", addr1, instr1);
            end else begin
                e = q1.pop_front();
                if ({addr1, instr1} !== e) begin
                    bad++;
                    $display("FAIL write1 got addr=%h instr=%h want addr=%h instr=%h",
                             addr1, instr1, e[47:16], e[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL handshake_timeout got ready=%b want 1", rdy0);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (hold0 !== 1'b1 || hold1 !== 1'b1 || rdy0 !== 1'b1 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL armed got hold=%b/%b ready=%b done=%b want hold=1/1 ready=1 done=0",
                     hold0, hold1, rdy0, done0);
        end
    endtask

    task automatic check_done(input string tag, input logic exp_err);
        total++;
        if (done0 !== 1'b1 || hold0 !== 1'b0 || rdy0 !== 1'b0 || err0 !== exp_err
            || done1 !== 1'b1 || hold1 !== 1'b0 || err1 !== exp_err) begin
            bad++;
            $display("FAIL %s_done got done=%b/%b hold=%b/%b ready=%b err=%b/%b want done=1 hold=0 ready=0 err=%b",
                     tag, done0, done1, hold0, hold1, rdy0, err0, err1, exp_err);
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_writes got pending=%0d/%0d want 0/0", tag, q0.size(), q1.size());
        end
    endtask

    // Full load of n halfwords from hw_buf; optional random gaps and a stray start mid-stream.
    task automatic run_load(input string tag, input int n, input int maxgap, input int start_at);
        logic [7:0]  c;
        logic [15:0] nn;
        int          g;
        c  = 8'h00;
        nn = 16'(n);
        pulse_start();
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        send_byte(nn[7:0], g);
        c ^= nn[7:0];
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        send_byte(nn[15:8], g);
        c ^= nn[15:8];
        for (int i = 0; i < n; i++) begin
            q0.push_back({BASE0 + 32'(2 * i), hw_buf[i]});
            q1.push_back({BASE1 + 32'(2 * i), hw_buf[i]});
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (i == start_at) start = 1'b1;
            send_byte(hw_buf[i][7:0], g);
            start = 1'b0;
            c ^= hw_buf[i][7:0];
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            send_byte(hw_buf[i][15:8], g);
            c ^= hw_buf[i][15:8];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (n > 0) send_byte(c, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        check_done(tag, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (rdy0 !== 1'b0 || we0 !== 1'b0 || instr0 !== 16'h0 || addr0 !== BASE0
            || hold0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
            bad++;
            $display("FAIL %s_dut0 got rdy=%b we=%b instr=%h addr=%h hold=%b done=%b err=%b want all 0 addr=%h",
                     tag, rdy0, we0, instr0, addr0, hold0, done0, err0, BASE0);
        end
        total++;
        if (rdy1 !== 1'b0 || we1 !== 1'b0 || instr1 !== 16'h0 || addr1 !== BASE1
            || hold1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin
            bad++;
            $display("FAIL %s_dut1 got rdy=%b we=%b instr=%h addr=%h hold=%b done=%b err=%b want all 0 addr=%h",
                     tag, rdy1, we1, instr1, addr1, hold1, done1, err1, BASE1);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_basic();
        hw_buf[0] = 16'h1234;
        hw_buf[1] = 16'h5678;
        run_load("basic", 2, 0, -1);
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_done("zero_len", 1'b0);
    endtask

    task automatic test_bursty();
        hw_buf[0] = 16'hA1B2;
        hw_buf[1] = 16'hC3D4;
        hw_buf[2] = 16'hE5F6;
        hw_buf[3] = 16'h0718;
        run_load("bursty", 4, 5, -1);
    endtask

    task automatic test_done_ignores_bytes();
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rdy0 !== 1'b0 || done0 !== 1'b1) begin
                bad++;
                $display("FAIL done_idle_bytes got ready=%b done=%b want ready=0 done=1", rdy0, done0);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        hw_buf[0] = 16'h1111;
        hw_buf[1] = 16'h2222;
        hw_buf[2] = 16'h3333;
        run_load("start_ignored", 3, 0, 1);
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h99, 0);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midload_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        hw_buf[0] = 16'hBEEF;
        hw_buf[1] = 16'hCAFE;
        hw_buf[2] = 16'hF00D;
        run_load("after_reset", 3, 0, -1);
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        q0.push_back({BASE0, 16'hABCD});
        q1.push_back({BASE1, 16'hABCD});
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h67, 0);
        @(negedge clk);
        check_done("csum_good", 1'b0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        q0.push_back({BASE0, 16'hABCD});
        q1.push_back({BASE1, 16'hABCD});
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check_done("csum_bad", 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_bursty();
        test_done_ignores_bytes();
        test_start_ignored();
        test_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
